uart_rxsm: RTL and testbench

- UART receive state machine; the serial-side counterpart of the transmit state machine.
- Oversamples the serial input RxD at 16x using the shared CE_16x enable.
- Validates the start bit at mid-bit, then shifts in 7/8 data bits, an optional parity bit and 1/2 stop bits.
- Writes each completed character with its error flags into the receive FIFO (RF_WE/RF_FF handshake).

---
 rtl/uart_rxsm.sv | 203 ++++++++++++++++++++
 tb/tb_uart_rxsm.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rxsm.sv
// UART receive state machine: 16x oversampled start/data/parity/stop capture into the RX FIFO.
// Optional break detection is enabled by defining UART_RXSM_BREAK_DET_EN.
module uart_rxsm #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned SAMPLE_PT   = 7
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       CE_16x,
  input  logic       Len,
  input  logic       NumStop,
  input  logic       ParEn,
  input  logic [1:0] Par,
  input  logic       RxD,
  input  logic       RF_FF,
  output logic       RF_WE,
  output logic [7:0] RHR,
  output logic       RxPE,
  output logic       RxFE,
  output logic       RxBI,
  output logic       RxOE,
  output logic       RxIdle,
  output logic [3:0] RxSM
);

  typedef enum logic [3:0] {
    Idle     = 4'd0,
    StartChk = 4'd1,
    Data     = 4'd2,
    Parity   = 4'd3,
    Stop1    = 4'd4,
    Stop2    = 4'd5
  } state_e;

  localparam logic [3:0] SamplePt = 4'(SAMPLE_PT);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxd_s;
  state_e                 state_q;
  logic [3:0]             bcnt_q;
  logic [2:0]             bitcnt_q;
  logic                   armed_q;
  logic                   len_q, nstop_q, paren_q;
  logic [1:0]             par_q;
  logic [7:0]             shift_q;
  logic                   pe_q, fe_q, done_q;
  logic                   bit_tick;
  logic                   par_exp;
  logic                   brk;
`ifdef UART_RXSM_BREAK_DET_EN
  logic                   par_zero_q, brk_q;
`endif

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) sync_q <= '1;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], RxD};
  end
  assign rxd_s = sync_q[SYNC_STAGES-1];

  assign bit_tick = CE_16x && (bcnt_q == 4'd15);

  always_comb begin
    par_exp = 1'b0;
    unique case (par_q)
      2'b00: par_exp = ~^shift_q;
      2'b01: par_exp = ^shift_q;
      2'b10: par_exp = 1'b0;
      2'b11: par_exp = 1'b1;
      default: par_exp = 1'b0;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= Idle;
      bcnt_q   <= '0;
      bitcnt_q <= '0;
      armed_q  <= 1'b0;
      len_q    <= 1'b0;
      nstop_q  <= 1'b0;
      paren_q  <= 1'b0;
      par_q    <= '0;
      shift_q  <= '0;
      pe_q     <= 1'b0;
      fe_q     <= 1'b0;
      done_q   <= 1'b0;
`ifdef UART_RXSM_BREAK_DET_EN
      par_zero_q <= 1'b0;
      brk_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        Idle: if (CE_16x) begin
          bcnt_q <= '0;
          if (rxd_s) begin
            armed_q <= 1'b1;
          end else if (armed_q) begin
            state_q <= StartChk;
            armed_q <= 1'b0;
            len_q   <= Len;
            nstop_q <= NumStop;
            paren_q <= ParEn;
            par_q   <= Par;
          end
        end
        StartChk: if (CE_16x) begin
          bcnt_q <= bcnt_q + 4'd1;
          if (bcnt_q == SamplePt) begin
            if (rxd_s) begin
              state_q <= Idle;
            end else begin
              state_q  <= Data;
              bcnt_q   <= '0;
              bitcnt_q <= '0;
              shift_q  <= '0;
              pe_q     <= 1'b0;
`ifdef UART_RXSM_BREAK_DET_EN
              par_zero_q <= 1'b1;
`endif
            end
          end
        end
        Data: if (CE_16x) begin
          bcnt_q <= bcnt_q + 4'd1;
          if (bit_tick) begin
            shift_q[bitcnt_q] <= rxd_s;
            bitcnt_q          <= bitcnt_q + 3'd1;
            if (bitcnt_q == (len_q ? 3'd6 : 3'd7)) state_q <= paren_q ? Parity : Stop1;
          end
        end
        Parity: if (CE_16x) begin
          bcnt_q <= bcnt_q + 4'd1;
          if (bit_tick) begin
            pe_q    <= (rxd_s != par_exp);
            state_q <= Stop1;
`ifdef UART_RXSM_BREAK_DET_EN
            par_zero_q <= ~rxd_s;
`endif
          end
        end
        Stop1: if (CE_16x) begin
          bcnt_q <= bcnt_q + 4'd1;
          if (bit_tick) begin
            fe_q <= ~rxd_s;
`ifdef UART_RXSM_BREAK_DET_EN
            brk_q <= (shift_q == 8'h00) && par_zero_q && ~rxd_s;
`endif
            if (nstop_q) begin
              state_q <= Stop2;
            end else begin
              state_q <= Idle;
              done_q  <= 1'b1;
            end
          end
        end
        Stop2: if (CE_16x) begin
          bcnt_q <= bcnt_q + 4'd1;
          if (bit_tick) begin
            fe_q    <= fe_q | ~rxd_s;
            state_q <= Idle;
            done_q  <= 1'b1;
          end
        end
        // Unused encodings recover on the next clock, independent of CE_16x.
        default: state_q <= Idle;
      endcase
    end
  end

`ifdef UART_RXSM_BREAK_DET_EN
  assign brk = brk_q;
`else
  assign brk = 1'b0;
`endif

  // Completion is committed one clock after the final stop sample.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      RF_WE <= 1'b0;
      RxOE  <= 1'b0;
      RHR   <= '0;
      RxPE  <= 1'b0;
      RxFE  <= 1'b0;
      RxBI  <= 1'b0;
    end else begin
      RF_WE <= 1'b0;
      RxOE  <= 1'b0;
      if (done_q) begin
        RF_WE <= ~RF_FF;
        RxOE  <= RF_FF;
        RHR   <= brk ? 8'h00 : shift_q;
        RxPE  <= paren_q && pe_q && ~brk;
        RxFE  <= fe_q | brk;
        RxBI  <= brk;
      end
    end
  end

  assign RxIdle = (state_q == Idle);
  assign RxSM   = state_q;

endmodule

// File: tb/tb_uart_rxsm.sv
// Scoreboard bench for uart_rxsm: expected characters queued as frames are driven, popped on output.
module tb_uart_rxsm;

  localparam int Div     = 4;
  localparam int BitClks = 16 * Div;
  localparam int Sync    = 2;
`ifdef UART_RXSM_BREAK_DET_EN
  localparam logic BrkEn = 1'b1;
`else
  localparam logic BrkEn = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       CE_16x = 1'b0;
  logic       Len = 1'b0, NumStop = 1'b0, ParEn = 1'b0;
  logic [1:0] Par = 2'b00;
  logic       RxD = 1'b1;
  logic       RF_FF = 1'b0;
  logic       RF_WE, RxPE, RxFE, RxBI, RxOE, RxIdle;
  logic [7:0] RHR;
  logic [3:0] RxSM;

  uart_rxsm #(.SYNC_STAGES(Sync), .SAMPLE_PT(7)) dut (
    .Clk(Clk), .Rst(Rst), .CE_16x(CE_16x), .Len(Len), .NumStop(NumStop), .ParEn(ParEn),
    .Par(Par), .RxD(RxD), .RF_FF(RF_FF), .RF_WE(RF_WE), .RHR(RHR), .RxPE(RxPE),
    .RxFE(RxFE), .RxBI(RxBI), .RxOE(RxOE), .RxIdle(RxIdle), .RxSM(RxSM)
  );

  typedef struct packed {
    logic [7:0] rhr;
    logic       pe, fe, bi, oe;
  } exp_t;

  exp_t   exp_q[$];
  int     checks = 0;
  int     failures = 0;
  int     events = 0;
  longint cyc = 0;
  longint ev_cyc = 0;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    int n = 0;
    forever begin
      @(negedge Clk);
      CE_16x = (n == Div - 1);
      n = (n + 1) % Div;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor: every write or overrun pulse consumes one scoreboard entry.
  always @(negedge Clk) begin
    if (Rst && (RF_WE || RxOE)) begin
      exp_t e;
      events++;
      ev_cyc = cyc;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_output", {30'd0, RF_WE, RxOE}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("rf_we", RF_WE, !e.oe);
        check_eq("rx_oe", RxOE, e.oe);
        check_eq("rhr", RHR, e.rhr);
        check_eq("rx_pe", RxPE, e.pe);
        check_eq("rx_fe", RxFE, e.fe);
        check_eq("rx_bi", RxBI, e.bi);
      end
    end
  end

  function automatic logic calc_par(input logic [7:0] d, input int nbits, input logic [1:0] p);
    int ones = 0;
    for (int i = 0; i < nbits; i++) ones += int'(d[i]);
    case (p)
      2'b00:   return (ones % 2 == 0);
      2'b01:   return (ones % 2 == 1);
      2'b10:   return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  task automatic push(input logic [7:0] rhr, input logic pe, input logic fe, input logic bi,
                      input logic oe);
    exp_t e;
    e.rhr = rhr; e.pe = pe; e.fe = fe; e.bi = bi; e.oe = oe;
    exp_q.push_back(e);
  endtask

  task automatic drive_bit(input logic b);
    RxD = b;
    repeat (BitClks) @(negedge Clk);
  endtask

  task automatic send(input logic [7:0] d, input int nbits, input logic par_en,
                      input logic par_bit, input int nstop, input logic stop_val);
    drive_bit(1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(d[i]);
    if (par_en) drive_bit(par_bit);
    for (int s = 0; s < nstop; s++) drive_bit(stop_val);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout got=0x0 exp=0x1");
    $fatal(1, "watchdog");
  end

  initial begin
    longint start_cyc, lat;
    int     ev0;
    logic   p;

    repeat (5) @(negedge Clk);
    check_eq("reset_rxidle", RxIdle, 1'b1);
    check_eq("reset_rxsm", RxSM, 4'd0);
    check_eq("reset_rf_we", RF_WE, 1'b0);
    check_eq("reset_rhr", RHR, 8'h00);
    check_eq("reset_flags", {RxPE, RxFE, RxBI, RxOE}, 4'b0000);
    Rst = 1'b1;
    drive_bit(1'b1);
    drive_bit(1'b1);

    // 8N1, 0xA5, with start-to-write latency
    Len = 1'b0; ParEn = 1'b0; NumStop = 1'b0; Par = 2'b00;
    push(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    start_cyc = cyc;
    send(8'hA5, 8, 1'b0, 1'b0, 1, 1'b1);
    drive_bit(1'b1);
    lat = ev_cyc - start_cyc;
    check_eq("latency_8n1", (lat >= 608 + Sync && lat <= 608 + Sync + Div + 2), 1'b1);

    // 7O2, correct then flipped parity
    Len = 1'b1; ParEn = 1'b1; Par = 2'b00; NumStop = 1'b1;
    p = calc_par(8'h41, 7, 2'b00);
    push(8'h41, 1'b0, 1'b0, 1'b0, 1'b0);
    send(8'h41, 7, 1'b1, p, 2, 1'b1);
    drive_bit(1'b1);
    push(8'h41, 1'b1, 1'b0, 1'b0, 1'b0);
    send(8'h41, 7, 1'b1, ~p, 2, 1'b1);
    drive_bit(1'b1);

    // 8E1 framing error, line held low, then a clean frame
    Len = 1'b0; ParEn = 1'b1; Par = 2'b01; NumStop = 1'b0;
    push(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
    send(8'h3C, 8, 1'b1, calc_par(8'h3C, 8, 2'b01), 1, 1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    push(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    send(8'h55, 8, 1'b1, calc_par(8'h55, 8, 2'b01), 1, 1'b1);
    drive_bit(1'b1);

    // Glitch of 4 CE ticks
    ParEn = 1'b0;
    ev0 = events;
    RxD = 1'b0;
    repeat (4 * Div) @(negedge Clk);
    check_eq("glitch_startchk", RxSM, 4'd1);
    RxD = 1'b1;
    repeat (3 * BitClks) @(negedge Clk);
    check_eq("glitch_idle", RxSM, 4'd0);
    check_eq("glitch_no_output", events, ev0);

    // Overrun
    RF_FF = 1'b1;
    push(8'h7E, 1'b0, 1'b0, 1'b0, 1'b1);
    send(8'h7E, 8, 1'b0, 1'b0, 1, 1'b1);
    drive_bit(1'b1);
    RF_FF = 1'b0;

    // Break: 20 bit times low yields a single character
    ev0 = events;
    push(8'h00, 1'b0, 1'b1, BrkEn, 1'b0);
    RxD = 1'b0;
    repeat (20 * BitClks) @(negedge Clk);
    RxD = 1'b1;
    repeat (2 * BitClks) @(negedge Clk);
    check_eq("break_one_write", events, ev0 + 1);

    // Reset mid-frame
    ev0 = events;
    RxD = 1'b0;
    repeat (3 * BitClks) @(negedge Clk);
    check_eq("mid_frame_data", RxSM, 4'd2);
    Rst = 1'b0;
    #1;
    check_eq("mid_reset_rxidle", RxIdle, 1'b1);
    check_eq("mid_reset_rxsm", RxSM, 4'd0);
    @(negedge Clk);
    RxD = 1'b1;
    Rst = 1'b1;
    repeat (2 * BitClks) @(negedge Clk);
    check_eq("reset_no_write", events, ev0);

    // Reception resumes normally after reset
    push(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    send(8'h5A, 8, 1'b0, 1'b0, 1, 1'b1);
    drive_bit(1'b1);

    check_eq("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
